// File: rtl/id_ctrl_pkg.sv
// Shared encodings for the decode-stage hazard controller.
// Holds the opcode constants, mux select codes, FSM state and the branch stall helper.
package id_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [1:0] FWD_REG  = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_EX   = 2'd2;
    localparam logic [1:0] FWD_ZERO = 2'd3;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // A branch operand must wait for its producer to reach a stage that can forward to decode.
    function automatic logic [1:0] branchNeed(
        input logic [4:0] src,
        input logic [4:0] idexRd,
        input logic       idexMemread,
        input logic       idexRegwrite,
        input logic [4:0] exmemRd,
        input logic       exmemMemread
    );
        logic [1:0] need;
        need = 2'd0;
        if (src != 5'd0) begin
            if (src == idexRd && idexMemread)
                need = 2'd2;
            else if (src == idexRd && idexRegwrite)
                need = 2'd1;
            else if (src == exmemRd && exmemMemread)
                need = 2'd1;
        end
        return need;
    endfunction

endpackage

// File: rtl/id_fwd_sel.sv
// Decode-stage forwarding select for one source operand.
// An EX/MEM load cannot forward yet, so that case falls through to MEM/WB.
module id_fwd_sel
    import id_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_exmem_regwrite,
    input  logic       i_exmem_memread,
    input  logic [4:0] i_exmem_rd,
    input  logic       i_memwb_regwrite,
    input  logic [4:0] i_memwb_rd,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_REG;
        if (i_src != 5'd0) begin
            if (i_exmem_regwrite && !i_exmem_memread && i_exmem_rd == i_src)
                o_sel = FWD_EX;
            else if (i_memwb_regwrite && i_memwb_rd == i_src)
                o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/redirect controller for the 5-stage MIPS pipeline.
// Drives branch forwarding, PC select, stall sequencing and saturating perf counters.
module id_hazard_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             id_valid,
    input  logic             cmp_eq,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_regwrite,
    input  logic             exmem_memread,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    output logic [1:0]       forbranchA,
    output logic [1:0]       forbranchB,
    output logic [1:0]       PCsrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             branch_taken,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic       w_isBranch;
    logic       w_isJump;
    logic       w_isJr;
    logic       w_rsUsed;
    logic       w_rtUsed;
    logic [4:0] w_srcA;
    logic [4:0] w_srcB;
    logic [1:0] w_needA;
    logic [1:0] w_needB;
    logic       w_loadUse;
    logic [1:0] w_need;
    logic       w_stall;
    logic       w_redirect;

    assign w_isBranch = id_valid && (opcode == OP_BEQ || opcode == OP_BNE);
    assign w_isJump   = id_valid && (opcode == OP_J || opcode == OP_JAL);
    assign w_isJr     = id_valid && opcode == OP_RTYPE && funct == FN_JR;
    assign w_rsUsed   = id_valid && !w_isJump && rs != 5'd0;
    assign w_rtUsed   = id_valid && !w_isJump && !w_isJr && rt != 5'd0;

    // Register 0 and unused operands are presented as 0 so they never forward.
    assign w_srcA = (w_rsUsed && !reset) ? rs : 5'd0;
    assign w_srcB = (w_rtUsed && !reset) ? rt : 5'd0;

    id_fwd_sel u_fwdA (
        .i_src            (w_srcA),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_memread  (exmem_memread),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (forbranchA)
    );

    id_fwd_sel u_fwdB (
        .i_src            (w_srcB),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_memread  (exmem_memread),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (forbranchB)
    );

    assign w_needA = (w_isBranch || w_isJr) && w_rsUsed
                   ? branchNeed(rs, idex_rd, idex_memread, idex_regwrite, exmem_rd, exmem_memread)
                   : 2'd0;
    assign w_needB = w_isBranch && w_rtUsed
                   ? branchNeed(rt, idex_rd, idex_memread, idex_regwrite, exmem_rd, exmem_memread)
                   : 2'd0;
    assign w_loadUse = idex_memread &&
                       ((w_rsUsed && rs == idex_rd) || (w_rtUsed && rt == idex_rd));

    always_comb begin
        w_need = (w_needA > w_needB) ? w_needA : w_needB;
        if (w_loadUse && w_need == 2'd0)
            w_need = 2'd1;
    end

    // Reset dominates, then HOLD, then a fresh stall, then redirect or normal flow.
    always_comb begin
        w_nextState  = r_state;
        w_stall      = 1'b0;
        w_redirect   = 1'b0;
        PCsrc        = PC_SEQ;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        branch_taken = 1'b0;
        if (reset) begin
            w_nextState = ST_RUN;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end else if (r_state == ST_HOLD || w_need != 2'd0) begin
            w_stall     = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_nextState = (r_state == ST_RUN && w_need == 2'd2) ? ST_HOLD : ST_RUN;
        end else begin
            if (w_isJump) begin
                PCsrc      = PC_JUMP;
                w_redirect = 1'b1;
            end else if (w_isBranch && ((opcode == OP_BEQ) == cmp_eq)) begin
                PCsrc      = PC_BRANCH;
                w_redirect = 1'b1;
            end else if (w_isJr) begin
                PCsrc      = PC_REG;
                w_redirect = 1'b1;
            end
            branch_taken = w_redirect;
            ifid_flush   = w_redirect;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_stall && r_stallCnt != CNT_MAX)
                r_stallCnt <= r_stallCnt + 1'b1;
            if (w_redirect && r_flushCnt != CNT_MAX)
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign stall_cycles = r_stallCnt;
    assign flush_count  = r_flushCnt;

endmodule
